// File: rtl/rx_gasket_pkg.sv
// Shared definitions for the receive-side gasket: MAC width codes, the
// comma symbol and the lane-index helper.
// Optional comma alignment is enabled with RX_GASKET_COMMA_ALIGN_EN.
package gasket_pkg;

  localparam logic [5:0] WIDTH_8   = 6'd8;
  localparam logic [5:0] WIDTH_16  = 6'd16;
  localparam logic [5:0] WIDTH_32  = 6'd32;
  localparam logic [7:0] COM_K28_5 = 8'hBC;

  typedef logic [1:0] lane_idx_t;

  // Index of the last lane of a word for a given MAC width code.
  // Unknown width codes behave as 8-bit.
  function automatic lane_idx_t terminal_idx(input logic [5:0] width);
    case (width)
      WIDTH_16: terminal_idx = 2'd1;
      WIDTH_32: terminal_idx = 2'd3;
      default:  terminal_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rx_lane_ctrl.sv
// Lane sequencing for the RX gasket: keeps the lane index and the
// registered bus width, detects width changes and (with
// RX_GASKET_COMMA_ALIGN_EN defined) forces commas back into lane 0.
//
// Outputs for the current cycle:
//   idx     lane the current symbol is written to
//   term    last lane of a word at the current width
//   close   current valid symbol completes the word
//   flush   partial word must be discarded before this symbol lands
//   realign a comma forced realignment (always 0 without the macro)
module rx_lane_ctrl
  import gasket_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL = COM_K28_5
) (
  input  logic      clk,
  input  logic      rst,
  input  logic [5:0] width,
  input  logic      rx_valid,
  input  logic [7:0] rx_data,
  input  logic      rx_datak,
  output lane_idx_t idx,
  output lane_idx_t term,
  output logic      close,
  output logic      flush,
  output logic      realign
);

  lane_idx_t  idx_q;
  lane_idx_t  idx_nxt;
  logic [5:0] width_q;
  logic       width_chg;
  logic       is_com;

  // Effective lane, word close / flush decisions and next lane index.
  always_comb begin
    width_chg = (width != width_q);
    is_com    = rx_datak && (rx_data == COM_SYMBOL);
    term      = terminal_idx(width);
`ifdef RX_GASKET_COMMA_ALIGN_EN
    realign   = rx_valid && is_com && (idx_q != 2'd0) && !width_chg;
`else
    realign   = is_com & 1'b0;
`endif
    flush     = width_chg || realign;
    idx       = flush ? 2'd0 : idx_q;
    close     = rx_valid && (idx == term);
    idx_nxt   = idx;
    if (rx_valid) begin
      idx_nxt = close ? 2'd0 : idx + 2'd1;
    end
  end

  // Lane index and registered width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 2'd0;
      width_q <= WIDTH_8;
    end else begin
      idx_q   <= idx_nxt;
      width_q <= width;
    end
  end

endmodule

// File: rtl/rx_gasket.sv
// Receive-side PHY gasket: packs decoded 8-bit symbols into 8/16/32-bit
// MAC words, first symbol in lane 0 (bits [7:0]).
// Optional feature macro: RX_GASKET_COMMA_ALIGN_EN (comma realignment,
// drives Align_Lost); without it Align_Lost stays 0.
//
// Handshake: RxValid qualifies RxData/RxDataK/RxDecodeErr for one cycle;
// there is no backpressure, RxValid=0 simply stalls assembly. The output
// side is a one-cycle MAC_RX_Valid strobe with no ready; MAC_RX_Data,
// MAC_RX_DataK and MAC_RX_Err are meaningful when MAC_RX_Valid=1 and hold
// their last value otherwise.
module rx_gasket
  import gasket_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter logic [7:0] COM_SYMBOL = COM_K28_5
) (
  input  logic                Bit_Rate_CLK_10,
  input  logic                Reset,
  input  logic [5:0]          DataBusWidth,
  input  logic [7:0]          RxData,
  input  logic                RxDataK,
  input  logic                RxValid,
  input  logic                RxDecodeErr,
  output logic [DATA_W-1:0]   MAC_RX_Data,
  output logic [DATA_W/8-1:0] MAC_RX_DataK,
  output logic                MAC_RX_Valid,
  output logic                MAC_RX_Err,
  output logic                Align_Lost
);

  localparam int LANES = DATA_W / 8;

  lane_idx_t           lane;
  lane_idx_t           term;
  logic                close;
  logic                flush;
  logic                realign;

  logic [DATA_W-1:0]   data_q;
  logic [LANES-1:0]    k_q;
  logic                err_q;
  logic                align_q;

  logic [DATA_W-1:0]   asm_data;
  logic [LANES-1:0]    asm_k;
  logic                asm_err;
  logic [LANES-1:0]    lane_mask;
  logic [DATA_W-1:0]   data_mask;

  rx_lane_ctrl #(
    .COM_SYMBOL (COM_SYMBOL)
  ) u_lane_ctrl (
    .clk      (Bit_Rate_CLK_10),
    .rst      (Reset),
    .width    (DataBusWidth),
    .rx_valid (RxValid),
    .rx_data  (RxData),
    .rx_datak (RxDataK),
    .idx      (lane),
    .term     (term),
    .close    (close),
    .flush    (flush),
    .realign  (realign)
  );

  // Merge the current symbol into the (possibly discarded) partial word
  // and build the mask that zeroes lanes above the current width.
  always_comb begin
    asm_data = flush ? '0 : data_q;
    asm_k    = flush ? '0 : k_q;
    asm_err  = (flush ? 1'b0 : err_q) | (RxValid & RxDecodeErr);
    if (RxValid) begin
      asm_data[{lane, 3'b000} +: 8] = RxData;
      asm_k[lane]                   = RxDataK;
    end
    for (int i = 0; i < LANES; i++) begin
      lane_mask[i]        = (lane_idx_t'(i) <= term);
      data_mask[8*i +: 8] = {8{lane_mask[i]}};
    end
  end

  // Assembly registers: cleared when a word closes, otherwise track the
  // merged partial word.
  always_ff @(posedge Bit_Rate_CLK_10 or posedge Reset) begin
    if (Reset) begin
      data_q <= '0;
      k_q    <= '0;
      err_q  <= 1'b0;
    end else if (close) begin
      data_q <= '0;
      k_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      data_q <= asm_data;
      k_q    <= asm_k;
      err_q  <= asm_err;
    end
  end

  // Output word register and strobe; data/K/err hold between strobes.
  always_ff @(posedge Bit_Rate_CLK_10 or posedge Reset) begin
    if (Reset) begin
      MAC_RX_Data  <= '0;
      MAC_RX_DataK <= '0;
      MAC_RX_Err   <= 1'b0;
      MAC_RX_Valid <= 1'b0;
    end else begin
      MAC_RX_Valid <= close;
      if (close) begin
        MAC_RX_Data  <= asm_data & data_mask;
        MAC_RX_DataK <= asm_k & lane_mask;
        MAC_RX_Err   <= asm_err;
      end
    end
  end

  // Realignment pulse, one cycle after the offending comma.
  always_ff @(posedge Bit_Rate_CLK_10 or posedge Reset) begin
    if (Reset) begin
      align_q <= 1'b0;
    end else begin
      align_q <= realign;
    end
  end

  assign Align_Lost = align_q;

endmodule

// File: tb/tb_rx_gasket.sv
// Directed bench for rx_gasket: linear sequence of symbol steps with
// hand-computed expected words, checked by immediate assertions.
module tb_rx_gasket;

  logic        clk;
  logic        rst;
  logic [5:0]  width;
  logic [7:0]  rx_data;
  logic        rx_datak;
  logic        rx_valid;
  logic        rx_err;
  logic [31:0] mac_data;
  logic [3:0]  mac_k;
  logic        mac_valid;
  logic        mac_err;
  logic        align_lost;

  int vectors;
  int miscompares;

  rx_gasket dut (
    .Bit_Rate_CLK_10 (clk),
    .Reset           (rst),
    .DataBusWidth    (width),
    .RxData          (rx_data),
    .RxDataK         (rx_datak),
    .RxValid         (rx_valid),
    .RxDecodeErr     (rx_err),
    .MAC_RX_Data     (mac_data),
    .MAC_RX_DataK    (mac_k),
    .MAC_RX_Valid    (mac_valid),
    .MAC_RX_Err      (mac_err),
    .Align_Lost      (align_lost)
  );

  // Clock: period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one symbol for one clock; returns 1 time unit after the edge
  // so outputs reflect that symbol.
  task automatic sym(input logic [7:0] d, input logic k, input logic e, input logic v);
    rx_data  = d;
    rx_datak = k;
    rx_err   = e;
    rx_valid = v;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    rx_datak = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic e);
    check({tag, "_valid"}, {31'd0, mac_valid}, 32'd1);
    check({tag, "_data"},  mac_data, d);
    check({tag, "_k"},     {28'd0, mac_k}, {28'd0, k});
    check({tag, "_err"},   {31'd0, mac_err}, {31'd0, e});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_novalid"}, {31'd0, mac_valid}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    width       = 6'd8;
    rx_data     = 8'h00;
    rx_datak    = 1'b0;
    rx_valid    = 1'b0;
    rx_err      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_data",  mac_data, 32'h0);
    check("rst_k",     {28'd0, mac_k}, 32'h0);
    check("rst_valid", {31'd0, mac_valid}, 32'h0);
    check("rst_err",   {31'd0, mac_err}, 32'h0);
    check("rst_align", {31'd0, align_lost}, 32'h0);
    rst = 1'b0;

    // Width 8, continuous stream: a strobe every cycle
    sym(8'h11, 1'b0, 1'b0, 1'b1);
    check_word("w8_a", 32'h00000011, 4'b0000, 1'b0);
    sym(8'h22, 1'b0, 1'b0, 1'b1);
    check_word("w8_b", 32'h00000022, 4'b0000, 1'b0);
    sym(8'h33, 1'b0, 1'b0, 1'b1);
    check_word("w8_c", 32'h00000033, 4'b0000, 1'b0);
    sym(8'h00, 1'b0, 1'b0, 1'b0);
    check_idle("w8_idle");
    check("w8_hold", mac_data, 32'h00000033);

    // Width 16, K28.5 then 0x4A with a 3-cycle stall between
    width = 6'd16;
    sym(8'hBC, 1'b1, 1'b0, 1'b1);
    check_idle("w16_first");
    for (int i = 0; i < 3; i++) begin
      sym(8'h00, 1'b0, 1'b0, 1'b0);
      check_idle("w16_gap");
    end
    sym(8'h4A, 1'b0, 1'b0, 1'b1);
    check_word("w16", 32'h00004ABC, 4'b0001, 1'b0);

    // Width 32 with a decode error on the second symbol, then a clean word
    width = 6'd32;
    sym(8'h01, 1'b0, 1'b0, 1'b1);
    sym(8'h02, 1'b0, 1'b1, 1'b1);
    sym(8'h03, 1'b0, 1'b0, 1'b1);
    check_idle("w32_partial");
    sym(8'h04, 1'b0, 1'b0, 1'b1);
    check_word("w32_err", 32'h04030201, 4'b0000, 1'b1);
    sym(8'h05, 1'b0, 1'b0, 1'b1);
    sym(8'h06, 1'b0, 1'b0, 1'b1);
    sym(8'h07, 1'b0, 1'b0, 1'b1);
    sym(8'h08, 1'b0, 1'b0, 1'b1);
    check_word("w32_clean", 32'h08070605, 4'b0000, 1'b0);

    // Width change mid-word: partial word dropped, new width starts at lane 0
    sym(8'hA1, 1'b0, 1'b0, 1'b1);
    sym(8'hA2, 1'b0, 1'b0, 1'b1);
    width = 6'd16;
    sym(8'hAA, 1'b0, 1'b0, 1'b1);
    check_idle("wchg_drop");
    sym(8'hBB, 1'b0, 1'b0, 1'b1);
    check_word("wchg", 32'h0000BBAA, 4'b0000, 1'b0);

    // Comma arriving mid-word at width 32
    width = 6'd32;
    sym(8'h10, 1'b0, 1'b0, 1'b1);
    sym(8'h20, 1'b0, 1'b0, 1'b1);
    sym(8'hBC, 1'b1, 1'b0, 1'b1);
`ifdef RX_GASKET_COMMA_ALIGN_EN
    check("com_align_pulse", {31'd0, align_lost}, 32'd1);
    check_idle("com_drop");
    sym(8'h30, 1'b0, 1'b0, 1'b1);
    check("com_align_clear", {31'd0, align_lost}, 32'd0);
    sym(8'h40, 1'b0, 1'b0, 1'b1);
    sym(8'h50, 1'b0, 1'b0, 1'b1);
    check_word("com_realigned", 32'h504030BC, 4'b0001, 1'b0);
`else
    check("com_no_pulse", {31'd0, align_lost}, 32'd0);
    sym(8'h30, 1'b0, 1'b0, 1'b1);
    check_word("com_plain", 32'h30BC2010, 4'b0100, 1'b0);
    check("com_no_pulse2", {31'd0, align_lost}, 32'd0);
    sym(8'h40, 1'b0, 1'b0, 1'b1);
    sym(8'h50, 1'b0, 1'b0, 1'b1);
    sym(8'h60, 1'b0, 1'b0, 1'b1);
    sym(8'h70, 1'b0, 1'b0, 1'b1);
    check_word("com_next", 32'h70605040, 4'b0000, 1'b0);
`endif

    // Asynchronous reset after 3 of 4 symbols
    sym(8'hE1, 1'b0, 1'b0, 1'b1);
    sym(8'hE2, 1'b0, 1'b0, 1'b1);
    sym(8'hE3, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_data",  mac_data, 32'h0);
    check("arst_k",     {28'd0, mac_k}, 32'h0);
    check("arst_valid", {31'd0, mac_valid}, 32'h0);
    check("arst_err",   {31'd0, mac_err}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sym(8'hC1, 1'b0, 1'b0, 1'b1);
    sym(8'hC2, 1'b0, 1'b0, 1'b1);
    sym(8'hC3, 1'b0, 1'b0, 1'b1);
    check_idle("post_rst_partial");
    sym(8'hC4, 1'b0, 1'b0, 1'b1);
    check_word("post_rst", 32'hC4C3C2C1, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
